// File: rtl/discr_deadtime_gen_pkg.sv
// Shared FSM states and lane-mask helpers for the discriminator scaler deadtime logic.
// Pure package: no latency, no backpressure.
package discr_scaler_pkg;

    localparam int LANE_MAX = 64;

    typedef enum logic [0:0] {
        S_IDLE      = 1'b0,
        S_INHIBITED = 1'b1
    } state_t;

    // Lanes strictly above k set.
    function automatic logic [LANE_MAX-1:0] thermo_above(input int k);
        logic [LANE_MAX-1:0] m;
        m = '0;
        for (int i = 0; i < LANE_MAX; i++) begin
            if (i > k) m[i] = 1'b1;
        end
        return m;
    endfunction

    // Lanes 0..k set.
    function automatic logic [LANE_MAX-1:0] thermo_upto(input int k);
        logic [LANE_MAX-1:0] m;
        m = '0;
        for (int i = 0; i < LANE_MAX; i++) begin
            if (i <= k) m[i] = 1'b1;
        end
        return m;
    endfunction

    function automatic logic [6:0] popcount(input logic [LANE_MAX-1:0] v);
        logic [6:0] c;
        c = '0;
        for (int i = 0; i < LANE_MAX; i++) begin
            c = c + 7'(v[i]);
        end
        return c;
    endfunction

endpackage

// File: rtl/discr_deadtime_gen_if.sv
// Sample/inhibit bundle between deserialiser, deadtime generator and scaler counters.
// Optional DEADTIME_STATS_EN adds stat_clr / inhibited_cnt. No backpressure: one word per clk.
interface discr_deadtime_gen_if #(
    parameter int P_LANES   = 8,
    parameter int P_N_WIDTH = 32
);
    logic [P_LANES-1:0]   bits_in;
    logic [P_N_WIDTH-1:0] inhibit_len;
    logic                 paralyzable;
    logic [P_LANES-1:0]   inhibit_bits;
    logic [P_LANES-1:0]   bits_out;
    logic [P_LANES-1:0]   accepted_bits;
`ifdef DEADTIME_STATS_EN
    logic                 stat_clr;
    logic [P_N_WIDTH-1:0] inhibited_cnt;
`endif

    modport master (
`ifdef DEADTIME_STATS_EN
        output stat_clr,
        input  inhibited_cnt,
`endif
        output bits_in, inhibit_len, paralyzable,
        input  inhibit_bits, bits_out, accepted_bits
    );

    modport slave (
`ifdef DEADTIME_STATS_EN
        input  stat_clr,
        output inhibited_cnt,
`endif
        input  bits_in, inhibit_len, paralyzable,
        output inhibit_bits, bits_out, accepted_bits
    );

endinterface

// File: rtl/discr_deadtime_gen_prio_enc.sv
// Lane priority encoder: valid plus index of the lowest (or highest, P_HIGHEST=1) set lane.
// Combinational, no backpressure.
module lane_prio_enc #(
    parameter int P_LANES   = 8,
    parameter bit P_HIGHEST = 1'b0
) (
    input  logic [P_LANES-1:0]         lanes,
    output logic                       vld,
    output logic [$clog2(P_LANES)-1:0] idx
);
    localparam int W = $clog2(P_LANES);

    always_comb begin
        vld = |lanes;
        idx = '0;
        if (P_HIGHEST) begin
            for (int i = 0; i < P_LANES; i++) begin
                if (lanes[i]) idx = W'(i);
            end
        end else begin
            for (int i = P_LANES - 1; i >= 0; i--) begin
                if (lanes[i]) idx = W'(i);
            end
        end
    end

endmodule

// File: rtl/discr_deadtime_gen.sv
// Deadtime (inhibit) generator on a P_LANES-wide sample word; `DEADTIME_STATS_EN adds a suppressed-edge counter.
// All outputs registered, 1 clk latency; no backpressure, a word is consumed every clk.
module discr_deadtime_gen
    import discr_scaler_pkg::*;
#(
    parameter int P_LANES   = 8,
    parameter int P_N_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    discr_deadtime_gen_if.slave  dif
);
    localparam int IW = $clog2(P_LANES);

    typedef logic [P_LANES-1:0] lanes_t;

    state_t               state, state_n;
    logic [P_N_WIDTH-1:0] cnt, cnt_n;
    logic [P_N_WIDTH-1:0] len_q;
    logic                 par_q;
    logic [IW-1:0]        bnd, bnd_n;
    lanes_t               carry, carry_n;
    logic                 prev_last;

    lanes_t               trig, free_trig, inhib_c, acc_c;
    logic                 lo_vld, hi_vld, start;
    logic [IW-1:0]        lo_idx, hi_idx, start_lane;

    function automatic lanes_t mask_above(input logic [IW-1:0] k);
        logic [LANE_MAX-1:0] m;
        m = thermo_above(int'(k));
        return m[P_LANES-1:0];
    endfunction

    function automatic lanes_t mask_upto(input logic [IW-1:0] k);
        logic [LANE_MAX-1:0] m;
        m = thermo_upto(int'(k));
        return m[P_LANES-1:0];
    endfunction

    assign trig      = dif.bits_in & ~{dif.bits_in[P_LANES-2:0], prev_last};
    assign free_trig = trig & ~carry;

    lane_prio_enc #(.P_LANES(P_LANES), .P_HIGHEST(1'b0)) u_lo_enc (
        .lanes (free_trig),
        .vld   (lo_vld),
        .idx   (lo_idx)
    );

    lane_prio_enc #(.P_LANES(P_LANES), .P_HIGHEST(1'b1)) u_hi_enc (
        .lanes (trig),
        .vld   (hi_vld),
        .idx   (hi_idx)
    );

    always_comb begin
        inhib_c    = '0;
        acc_c      = '0;
        state_n    = state;
        cnt_n      = cnt;
        bnd_n      = bnd;
        carry_n    = carry;
        start      = 1'b0;
        start_lane = hi_idx;
        if (len_q == '0) begin
            acc_c   = trig;
            state_n = S_IDLE;
            carry_n = '0;
        end else begin
            case (state)
                S_IDLE: begin
                    carry_n = '0;
                    // A retrigger inside the carried-over deadtime covers every later lane of this word.
                    if (par_q && |(trig & carry)) begin
                        inhib_c    = '1;
                        start      = 1'b1;
                        start_lane = hi_idx;
                    end else if (lo_vld) begin
                        acc_c      = lanes_t'(1) << lo_idx;
                        inhib_c    = carry | mask_above(lo_idx);
                        start      = 1'b1;
                        start_lane = par_q ? hi_idx : lo_idx;
                    end else begin
                        inhib_c = carry;
                    end
                end
                S_INHIBITED: begin
                    inhib_c = '1;
                    if (par_q && hi_vld) begin
                        start      = 1'b1;
                        start_lane = hi_idx;
                    end else if (cnt >= len_q - P_N_WIDTH'(1)) begin
                        state_n = S_IDLE;
                        carry_n = mask_upto(bnd);
                    end else if (cnt != '1) begin
                        cnt_n = cnt + P_N_WIDTH'(1);
                    end
                end
                default: begin
                    state_n = S_IDLE;
                    carry_n = '0;
                    cnt_n   = '0;
                end
            endcase
            // The word holding the boundary lane counts as the first deadtime cycle.
            if (start) begin
                if (len_q == P_N_WIDTH'(1)) begin
                    state_n = S_IDLE;
                    carry_n = mask_upto(start_lane);
                end else begin
                    state_n = S_INHIBITED;
                    cnt_n   = P_N_WIDTH'(1);
                    bnd_n   = start_lane;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state             <= S_IDLE;
            cnt               <= '0;
            bnd               <= '0;
            carry             <= '0;
            len_q             <= '0;
            par_q             <= 1'b0;
            prev_last         <= 1'b0;
            dif.inhibit_bits  <= '0;
            dif.bits_out      <= '0;
            dif.accepted_bits <= '0;
        end else begin
            state             <= state_n;
            cnt               <= cnt_n;
            bnd               <= bnd_n;
            carry             <= carry_n;
            len_q             <= dif.inhibit_len;
            par_q             <= dif.paralyzable;
            prev_last         <= dif.bits_in[P_LANES-1];
            dif.inhibit_bits  <= inhib_c;
            dif.bits_out      <= dif.bits_in;
            dif.accepted_bits <= acc_c;
        end
    end

`ifdef DEADTIME_STATS_EN
    localparam int SW = P_N_WIDTH + 1;

    logic [LANE_MAX-1:0] hit_w;
    logic [SW-1:0]       stat_sum;

    always_comb begin
        hit_w              = '0;
        hit_w[P_LANES-1:0] = trig & inhib_c;
    end

    assign stat_sum = {1'b0, dif.inhibited_cnt} + SW'(popcount(hit_w));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dif.inhibited_cnt <= '0;
        end else if (dif.stat_clr) begin
            dif.inhibited_cnt <= '0;
        end else if (stat_sum[P_N_WIDTH]) begin
            dif.inhibited_cnt <= '1;
        end else begin
            dif.inhibited_cnt <= stat_sum[P_N_WIDTH-1:0];
        end
    end
`endif

endmodule

// File: tb/tb_discr_deadtime_gen.sv
// Scoreboard bench for discr_deadtime_gen (P_LANES=8); expectations from constants and a per-sample deadtime model.
`timescale 1ns/1ps
module tb_discr_deadtime_gen;

    logic clk = 1'b0;
    logic rst = 1'b1;

    discr_deadtime_gen_if #(.P_LANES(8), .P_N_WIDTH(32)) dif ();
    discr_deadtime_gen #(.P_LANES(8), .P_N_WIDTH(32)) dut (.clk(clk), .rst(rst), .dif(dif));

`ifdef DEADTIME_STATS_EN
    discr_deadtime_gen_if #(.P_LANES(8), .P_N_WIDTH(4)) dif4 ();
    discr_deadtime_gen #(.P_LANES(8), .P_N_WIDTH(4)) dut4 (.clk(clk), .rst(rst), .dif(dif4));
`endif

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0]  inh;
        logic [7:0]  out;
        logic [7:0]  acc;
        logic [31:0] cnt;
    } exp_t;

    exp_t        sb[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    string       phase   = "reset";

    // Sample-serial reference: rem = number of upcoming samples still inside deadtime.
    longint      rem     = 0;
    logic        prev    = 1'b0;
    int unsigned m_len   = 0;
    logic        m_par   = 1'b0;
    int unsigned m_cnt   = 0;
    logic        clr     = 1'b0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s/%s: got %0h expected %0h", phase, tag, obs, expv);
        end
    endtask

    function automatic exp_t model_step(input logic [7:0] b, input int unsigned len, input logic par);
        exp_t e;
        e     = '0;
        e.out = b;
        for (int i = 0; i < 8; i++) begin
            logic t;
            t    = b[i] & ~prev;
            prev = b[i];
            if (m_len == 0) begin
                e.acc[i] = t;
                rem      = 0;
            end else if (rem > 0) begin
                e.inh[i] = 1'b1;
                rem--;
                if (t) begin
                    m_cnt++;
                    if (m_par) rem = longint'(m_len) * 8;
                end
            end else if (t) begin
                e.acc[i] = 1'b1;
                rem      = longint'(m_len) * 8;
            end
        end
        if (clr) m_cnt = 0;
        e.cnt = m_cnt;
        m_len = len;
        m_par = par;
        return e;
    endfunction

    task automatic pop_check();
        exp_t e;
        if (sb.size() == 0) return;
        e = sb.pop_front();
        check_val("inhibit_bits", 32'(dif.inhibit_bits), 32'(e.inh));
        check_val("bits_out", 32'(dif.bits_out), 32'(e.out));
        check_val("accepted_bits", 32'(dif.accepted_bits), 32'(e.acc));
`ifdef DEADTIME_STATS_EN
        check_val("inhibited_cnt", dif.inhibited_cnt, e.cnt);
`endif
    endtask

    task automatic cyc(input logic [7:0] b, input int unsigned len, input logic par,
                       input logic use_c = 1'b0, input logic [7:0] c_inh = 8'h00,
                       input logic [7:0] c_acc = 8'h00);
        exp_t e;
        @(posedge clk);
        #1;
        pop_check();
        dif.bits_in     = b;
        dif.inhibit_len = len;
        dif.paralyzable = par;
`ifdef DEADTIME_STATS_EN
        dif.stat_clr    = clr;
`endif
        e = model_step(b, len, par);
        if (use_c) begin
            e.inh = c_inh;
            e.acc = c_acc;
        end
        sb.push_back(e);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned seg_len[4] = '{3, 3, 1, 2};
        logic        seg_par[4] = '{1'b0, 1'b1, 1'b1, 1'b0};

        dif.bits_in     = '0;
        dif.inhibit_len = '0;
        dif.paralyzable = 1'b0;
`ifdef DEADTIME_STATS_EN
        dif.stat_clr     = 1'b0;
        dif4.bits_in     = 8'h55;
        dif4.inhibit_len = 4'd1;
        dif4.paralyzable = 1'b1;
        dif4.stat_clr    = 1'b0;
`endif
        #12;
        check_val("rst_inhibit", 32'(dif.inhibit_bits), 32'h0);
        check_val("rst_bits_out", 32'(dif.bits_out), 32'h0);
        check_val("rst_accepted", 32'(dif.accepted_bits), 32'h0);
        #1 rst = 1'b0;

        phase = "L2_single";
        cyc(8'h00, 2, 0, 1, 8'h00, 8'h00);
        cyc(8'h08, 2, 0, 1, 8'hF0, 8'h08);
        cyc(8'h00, 2, 0, 1, 8'hFF, 8'h00);
        cyc(8'h00, 2, 0, 1, 8'h0F, 8'h00);
        cyc(8'h00, 2, 0, 1, 8'h00, 8'h00);

        phase = "L1_carry";
        cyc(8'h00, 1, 0, 1, 8'h00, 8'h00);
        cyc(8'h40, 1, 0, 1, 8'h80, 8'h40);
        cyc(8'h80, 1, 0, 1, 8'h7F, 8'h80);
        cyc(8'h00, 1, 0, 1, 8'hFF, 8'h00);
        cyc(8'h00, 1, 0, 1, 8'h00, 8'h00);

        phase = "L2_nonpar_retrig";
        cyc(8'h00, 2, 0, 1, 8'h00, 8'h00);
        cyc(8'h08, 2, 0, 1, 8'hF0, 8'h08);
        cyc(8'h20, 2, 0, 1, 8'hFF, 8'h00);
        cyc(8'h00, 2, 0, 1, 8'h0F, 8'h00);
        cyc(8'h00, 2, 0, 1, 8'h00, 8'h00);

        phase = "L2_par_retrig";
        cyc(8'h00, 2, 1, 1, 8'h00, 8'h00);
        cyc(8'h08, 2, 1, 1, 8'hF0, 8'h08);
        cyc(8'h20, 2, 1, 1, 8'hFF, 8'h00);
        cyc(8'h00, 2, 1, 1, 8'hFF, 8'h00);
        cyc(8'h00, 2, 1, 1, 8'h3F, 8'h00);
        cyc(8'h00, 2, 1, 1, 8'h00, 8'h00);

        phase = "L0_random";
        cyc(8'h00, 0, 0);
        for (int i = 0; i < 24; i++) cyc(8'($urandom), 0, 0);

        // Each segment ends with an L=0 word, which may cut a deadtime short.
        for (int s = 0; s < 4; s++) begin
            phase = $sformatf("rand_L%0d_par%0d", seg_len[s], seg_par[s]);
            cyc(8'h00, seg_len[s], seg_par[s]);
            for (int i = 0; i < 40; i++) begin
                if (i % 3 == 0) cyc(8'($urandom), seg_len[s], seg_par[s]);
                else            cyc(8'($urandom & $urandom & $urandom), seg_len[s], seg_par[s]);
            end
            cyc(8'($urandom), 0, seg_par[s]);
        end

        phase = "L4_async_rst";
        cyc(8'h00, 4, 0, 1, 8'h00, 8'h00);
        cyc(8'h01, 4, 0, 1, 8'hFE, 8'h01);
        cyc(8'h00, 4, 0, 1, 8'hFF, 8'h00);
        cyc(8'h10, 4, 0, 1, 8'hFF, 8'h00);
        @(posedge clk);
        #1;
        pop_check();
        dif.bits_in = 8'h00;
        #2 rst = 1'b1;
        #1;
        check_val("arst_inhibit", 32'(dif.inhibit_bits), 32'h0);
        check_val("arst_bits_out", 32'(dif.bits_out), 32'h0);
        check_val("arst_accepted", 32'(dif.accepted_bits), 32'h0);
        #1 rst = 1'b0;
        sb.delete();
        rem   = 0;
        prev  = 1'b0;
        m_len = 0;
        m_par = 1'b0;
        m_cnt = 0;
        sb.push_back(model_step(8'h00, 4, 0));
        cyc(8'h02, 4, 0, 1, 8'hFC, 8'h02);
        for (int i = 0; i < 5; i++) cyc(8'h00, 4, 0);

`ifdef DEADTIME_STATS_EN
        phase = "stats";
        clr = 1'b1;
        cyc(8'h00, 3, 0);
        clr = 1'b0;
        cyc(8'h01, 3, 0);
        cyc(8'h0A, 3, 0);
        cyc(8'h04, 3, 0);
        cyc(8'h00, 3, 0);
        check_val("stats_three", dif.inhibited_cnt, 32'd3);
        clr = 1'b1;
        cyc(8'h00, 3, 0);
        clr = 1'b0;
        cyc(8'h00, 3, 0);
        check_val("stats_clear", dif.inhibited_cnt, 32'd0);
        check_val("stats_sat4", 32'(dif4.inhibited_cnt), 32'hF);
`endif

        phase = "drain";
        cyc(8'h00, 0, 0);
        @(posedge clk);
        #1;
        pop_check();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
